wlan_scrambler: RTL and testbench

- Transmit-side 802.11 frame-synchronous scrambler, polynomial S(x) = x^7 + x^4 + 1. It is the counterpart of the receive-path descrambler.
- Sits between the TX bit source (SERVICE + PSDU + tail + pad, serial) and the convolutional encoder.
- Each frame is armed with a 7-bit seed and a bit length. It takes one bit per cycle through a valid/ready handshake and emits scrambled bits.
- The last TAIL_BITS bits of the frame are forced to zero after scrambling, as 802.11 requires.

---
 rtl/wlan_scrambler_if.sv | 27 ++
 rtl/wlan_scrambler.sv | 96 +++++++++
 tb/tb_wlan_scrambler.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wlan_scrambler_if.sv
// Frame arm, bit-serial input handshake and scrambled output bundle.
// master = bit source / controller side, slave = scrambler side.
interface wlan_scrambler_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [6:0]       seed_in;
    logic [LEN_W-1:0] frame_len;
    logic             in_valid;
    logic             in_bit;
    logic             in_ready;
    logic             out_valid;
    logic             out_bit;
    logic             out_last;
    logic             busy;
    logic             done;

    modport master (
        output start, seed_in, frame_len, in_valid, in_bit,
        input  in_ready, out_valid, out_bit, out_last, busy, done
    );

    modport slave (
        input  start, seed_in, frame_len, in_valid, in_bit,
        output in_ready, out_valid, out_bit, out_last, busy, done
    );
endinterface

// File: rtl/wlan_scrambler.sv
// 802.11 TX scrambler, S(x)=x^7+x^4+1, with tail zeroing; one registered output bit per accepted input bit.
// Latency 1 cycle; input stalls via in_ready outside RUN, output has no backpressure.
module wlan_scrambler #(
    parameter int         LEN_W        = 16,
    parameter int         TAIL_BITS    = 6,
    parameter logic [6:0] SEED_DEFAULT = 7'b1011101
) (
    input  logic           clk,
    input  logic           reset,
    wlan_scrambler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [LEN_W:0] TAIL_EXT = (LEN_W + 1)'(TAIL_BITS);

    state_t           state;
    logic [6:0]       lfsr;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len;

    logic fb;
    logic xfer;
    logic in_tail;
    logic is_last;

    assign fb      = lfsr[6] ^ lfsr[3];
    assign xfer    = bus.in_valid & bus.in_ready;
    // cnt >= len-TAIL_BITS, rearranged so short frames cannot underflow
    assign in_tail = ({1'b0, cnt} + TAIL_EXT) >= {1'b0, len};
    assign is_last = (cnt == (len - LEN_W'(1)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            lfsr          <= 7'd0;
            cnt           <= '0;
            len           <= '0;
            bus.in_ready  <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_bit   <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lfsr     <= (bus.seed_in == 7'd0) ? SEED_DEFAULT : bus.seed_in;
                        cnt      <= '0;
                        len      <= bus.frame_len;
                        bus.busy <= 1'b1;
                        if (bus.frame_len == '0) begin
                            state        <= FIN;
                            bus.done     <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end else begin
                            state        <= RUN;
                            bus.in_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (xfer) begin
                        lfsr          <= {lfsr[5:0], fb};
                        cnt           <= cnt + LEN_W'(1);
                        bus.out_valid <= 1'b1;
                        bus.out_bit   <= in_tail ? 1'b0 : (bus.in_bit ^ fb);
                        bus.out_last  <= is_last;
                        if (is_last) begin
                            state        <= FIN;
                            bus.done     <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                FIN: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.in_ready <= 1'b0;
                    bus.busy     <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wlan_scrambler.sv
// Randomized bench for wlan_scrambler against a sequence-level reference of the x^7+x^4+1 scrambler.
module tb_wlan_scrambler;
    logic clk;
    logic reset;

    wlan_scrambler_if #(.LEN_W(16)) bus ();

    wlan_scrambler #(
        .LEN_W(16),
        .TAIL_BITS(6),
        .SEED_DEFAULT(7'b1011101)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    bit obs_q[$];
    bit last_q[$];
    int done_n    = 0;
    int done_ok_n = 0;

    bit data_q[$];
    bit exp_q[$];
    int frame_base;
    int done_base;
    int ok_base;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_valid) begin
            obs_q.push_back(bus.out_bit);
            last_q.push_back(bus.out_last);
        end
        if (bus.done) begin
            done_n++;
            if (bus.out_valid && bus.out_last) done_ok_n++;
        end
    end

    // Scrambler sequence as a recurrence on the bit stream: x[n+7] = x[n] ^ x[n+3],
    // with the seed supplying x[0..6] MSB first.
    task automatic build_model(input logic [6:0] seed, input int len);
        bit s[$];
        logic [6:0] sd;
        sd = (seed == 7'd0) ? 7'b1011101 : seed;
        exp_q.delete();
        for (int k = 0; k < 7; k++) s.push_back(sd[6-k]);
        for (int n = 0; n < len; n++) begin
            s.push_back(s[n] ^ s[n+3]);
            exp_q.push_back((n >= len - 6) ? 1'b0 : (data_q[n] ^ s[n+7]));
        end
    endtask

    task automatic fill_data(input int len, input bit rnd);
        data_q.delete();
        for (int i = 0; i < len; i++) data_q.push_back(rnd ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic run_frame(input string tag, input logic [6:0] seed, input int len,
                             input int gap_pct, input bit stray_start);
        int  i;
        int  cyc;
        bit  v;
        bit  ok;
        build_model(seed, len);
        @(posedge clk); #1;
        frame_base = obs_q.size();
        done_base  = done_n;
        ok_base    = done_ok_n;
        bus.start     = 1'b1;
        bus.seed_in   = seed;
        bus.frame_len = 16'(len);
        @(posedge clk); #1;
        bus.start = 1'b0;
        i   = 0;
        cyc = 0;
        while (i < len && cyc < len * 20 + 50) begin
            v = (gap_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= gap_pct);
            bus.in_valid = v;
            bus.in_bit   = data_q[i];
            if (stray_start && i == len / 2) begin
                bus.start     = 1'b1;
                bus.seed_in   = 7'($urandom_range(1, 127));
                bus.frame_len = 16'($urandom_range(1, 9));
            end else begin
                bus.start = 1'b0;
            end
            ok = v && bus.in_ready;
            @(posedge clk); #1;
            if (ok) i++;
            cyc++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (i < len) chk({tag, "_drive_timeout"}, i, len);
    endtask

    task automatic check_frame(input string tag, input int len);
        int waited;
        int lasts;
        waited = 0;
        while ((obs_q.size() - frame_base) < len && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, obs_q.size() - frame_base, len);
        if ((obs_q.size() - frame_base) >= len) begin
            for (int k = 0; k < len; k++) begin
                chk($sformatf("%s_bit%0d", tag, k), obs_q[frame_base+k], exp_q[k]);
            end
            lasts = 0;
            for (int k = 0; k < len; k++) lasts += int'(last_q[frame_base+k]);
            chk({tag, "_last_count"}, lasts, 1);
            chk({tag, "_last_pos"}, last_q[frame_base+len-1], 1);
        end
        chk({tag, "_done"}, done_n - done_base, 1);
        chk({tag, "_done_with_last"}, done_ok_n - ok_base, 1);
    endtask

    function automatic logic [6:0] outs();
        return {bus.in_ready, bus.out_valid, bus.out_bit, bus.out_last,
                bus.busy, bus.done, 1'b0};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit         seq_a[$];
        logic [15:0] pat;
        int         zb;

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.seed_in   = 7'd0;
        bus.frame_len = '0;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs(), 7'd0);
        #2 reset = 1'b0;

        // all-ones seed, 16 zero bits: known 802.11 sequence, last 6 tail-zeroed
        fill_data(16, 1'b0);
        run_frame("t1", 7'b1111111, 16, 0, 1'b0);
        check_frame("t1", 16);
        pat = '0;
        for (int k = 0; k < 16; k++) pat[15-k] = obs_q[frame_base+k];
        chk("t1_pattern", pat, 16'h0EC0);

        // period 127 and tail zeroing on a longer frame
        fill_data(140, 1'b0);
        run_frame("t2", 7'b1111111, 140, 0, 1'b0);
        check_frame("t2", 140);
        for (int k = 0; k < 7; k++)
            chk($sformatf("t2_period%0d", k), obs_q[frame_base+k], obs_q[frame_base+k+127]);
        zb = 0;
        for (int k = 134; k < 140; k++) zb += int'(obs_q[frame_base+k]);
        chk("t2_tail_zero", zb, 0);

        // zero seed falls back to the default seed
        fill_data(20, 1'b1);
        run_frame("t3a", 7'd0, 20, 0, 1'b0);
        check_frame("t3a", 20);
        seq_a.delete();
        for (int k = 0; k < 20; k++) seq_a.push_back(obs_q[frame_base+k]);
        run_frame("t3b", 7'b1011101, 20, 0, 1'b0);
        check_frame("t3b", 20);
        for (int k = 0; k < 20; k++)
            chk($sformatf("t3_same%0d", k), obs_q[frame_base+k], seq_a[k]);

        // frame not longer than the tail: all zero
        fill_data(4, 1'b1);
        data_q[0] = 1'b1;
        run_frame("t4", 7'd37, 4, 0, 1'b0);
        check_frame("t4", 4);

        // zero-length frame
        @(posedge clk); #1;
        frame_base    = obs_q.size();
        done_base     = done_n;
        bus.start     = 1'b1;
        bus.seed_in   = 7'd5;
        bus.frame_len = '0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4z_done", bus.done, 1);
        chk("t4z_busy", bus.busy, 1);
        chk("t4z_ready", bus.in_ready, 0);
        @(negedge clk);
        chk("t4z_done_end", bus.done, 0);
        chk("t4z_busy_end", bus.busy, 0);
        repeat (2) @(negedge clk);
        chk("t4z_no_out", obs_q.size() - frame_base, 0);
        chk("t4z_done_count", done_n - done_base, 1);

        // random gaps with a stray start mid-frame
        fill_data(50, 1'b1);
        run_frame("t5", 7'($urandom_range(1, 127)), 50, 35, 1'b1);
        check_frame("t5", 50);

        for (int r = 0; r < 4; r++) begin
            int rl;
            rl = $urandom_range(1, 60);
            fill_data(rl, 1'b1);
            run_frame($sformatf("rnd%0d", r), 7'($urandom_range(0, 127)), rl, 20, 1'b0);
            check_frame($sformatf("rnd%0d", r), rl);
        end

        // asynchronous reset mid-frame, then restart with a new seed
        @(posedge clk); #1;
        done_base     = done_n;
        bus.start     = 1'b1;
        bus.seed_in   = 7'd99;
        bus.frame_len = 16'd30;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_bit   = 1'b1;
        repeat (10) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("t6_reset_outputs", outs(), 7'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t6_reset_held", outs(), 7'd0);
        chk("t6_no_done", done_n - done_base, 0);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t6_idle_after", outs(), 7'd0);
        fill_data(24, 1'b1);
        run_frame("t6", 7'd81, 24, 10, 1'b0);
        check_frame("t6", 24);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
